hub75_scan_reader: RTL

- Downstream consumer of the 2-bit x 2048 dual-port framebuffer RAM.
- Drives the RAM read port (address, clock enable) and captures its 2-bit registered output, one bit for the top half-panel and one for the bottom half-panel.
- Serialises one row pair at a time to a HUB75 1-bit-per-half panel: panel clock, latch, output enable and row address.
- Runs continuously, row 0 to last row, and flags each completed frame.

---
 rtl/hub75_scan_pkg.sv | 18 +
 rtl/hub75_display_timer.sv | 52 +++++
 rtl/hub75_scan_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/hub75_scan_pkg.sv
// Shared types and constants for the HUB75 scan reader and its display timer.
package hub75_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        SHIFT,
        BLANK,
        LATCH,
        DISPLAY
    } scanState_e;

    localparam int RAM_ADDR_W = 11;
    localparam int RAM_DATA_W = 2;
    localparam int TOP_BIT    = 1;
    localparam int BOT_BIT    = 0;

endpackage

// File: rtl/hub75_display_timer.sv
// DISPLAY-phase down-counter with terminal-count flag and optional brightness gate.
// Optional feature macro: HUB75_SCAN_BRIGHTNESS_EN.
module hub75_display_timer #(
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       run,
`ifdef HUB75_SCAN_BRIGHTNESS_EN
    input  logic [7:0] brightness,
`endif
    output logic       lastCycle,
    output logic       litNext
);

    localparam int CNT_W = $clog2(DISPLAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DISPLAY_CYCLES - 1);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] countNext;

    always_comb begin
        countNext = count;
        if (load) begin
            countNext = LOAD_VAL;
        end else if (run && count != '0) begin
            countNext = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= countNext;
        end
    end

    assign lastCycle = (count == '0);

`ifdef HUB75_SCAN_BRIGHTNESS_EN
    // Elapsed cycles d = DISPLAY_CYCLES-1-count, so d < brightness <=> count + brightness >= DISPLAY_CYCLES.
    localparam int SUM_W = CNT_W + 9;
    logic [SUM_W-1:0] litSum;
    assign litSum  = SUM_W'(countNext) + SUM_W'(brightness);
    assign litNext = (litSum >= SUM_W'(DISPLAY_CYCLES));
`else
    assign litNext = 1'b1;
`endif

endmodule

// File: rtl/hub75_scan_reader.sv
// Reads the 2-bit framebuffer row pair by row pair and serialises it to a HUB75 panel.
// Optional feature macro: HUB75_SCAN_BRIGHTNESS_EN (adds brightness input, gates panel_oe_n).
module hub75_scan_reader
    import hub75_scan_pkg::*;
#(
    parameter int COL_BITS       = 6,
    parameter int ROW_BITS       = 5,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
`ifdef HUB75_SCAN_BRIGHTNESS_EN
    input  logic [7:0]            brightness,
`endif
    input  logic [RAM_DATA_W-1:0] ram_q,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic                  ram_clk_en,
    output logic                  pixel_top,
    output logic                  pixel_bottom,
    output logic                  panel_clk,
    output logic                  panel_latch,
    output logic                  panel_oe_n,
    output logic [ROW_BITS-1:0]   row_addr,
    output logic                  frame_done
);

    scanState_e          state;
    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                phase;
    logic                lastCycle;
    logic                litNext;

    logic [COL_BITS-1:0] colNext;
    logic [COL_BITS-1:0] colAfter;
    logic [ROW_BITS-1:0] rowNext;

    assign colNext  = col + COL_BITS'(1);
    assign colAfter = col + COL_BITS'(2);
    assign rowNext  = row + ROW_BITS'(1);

    hub75_display_timer #(
        .DISPLAY_CYCLES(DISPLAY_CYCLES)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (state == LATCH),
        .run       (state == DISPLAY),
`ifdef HUB75_SCAN_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .lastCycle (lastCycle),
        .litNext   (litNext)
    );

    // Outputs are registered for the state being entered, so they are valid throughout that state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            phase        <= 1'b0;
            ram_addr     <= '0;
            ram_clk_en   <= 1'b0;
            pixel_top    <= 1'b0;
            pixel_bottom <= 1'b0;
            panel_clk    <= 1'b0;
            panel_latch  <= 1'b0;
            panel_oe_n   <= 1'b1;
            row_addr     <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    panel_oe_n <= 1'b1;
                    ram_clk_en <= 1'b0;
                    if (enable) begin
                        state      <= PREFETCH;
                        ram_addr   <= {row, {COL_BITS{1'b0}}};
                        ram_clk_en <= 1'b1;
                    end
                end
                PREFETCH: begin
                    state      <= SHIFT;
                    phase      <= 1'b0;
                    panel_clk  <= 1'b0;
                    ram_addr   <= {row, colNext};
                    ram_clk_en <= (col != '1);
                end
                SHIFT: begin
                    if (!phase) begin
                        pixel_top    <= ram_q[TOP_BIT];
                        pixel_bottom <= ram_q[BOT_BIT];
                        panel_clk    <= 1'b1;
                        ram_clk_en   <= 1'b0;
                        phase        <= 1'b1;
                    end else begin
                        col       <= colNext;
                        phase     <= 1'b0;
                        panel_clk <= 1'b0;
                        if (col == '1) begin
                            state <= BLANK;
                        end else begin
                            ram_addr   <= {row, colAfter};
                            ram_clk_en <= (colNext != '1);
                        end
                    end
                end
                BLANK: begin
                    state       <= LATCH;
                    panel_latch <= 1'b1;
                end
                LATCH: begin
                    state       <= DISPLAY;
                    panel_latch <= 1'b0;
                    row_addr    <= row;
                    panel_oe_n  <= !litNext;
                end
                DISPLAY: begin
                    if (!lastCycle) begin
                        panel_oe_n <= !litNext;
                    end else begin
                        row        <= rowNext;
                        frame_done <= (row == '1);
                        panel_oe_n <= 1'b1;
                        if (enable) begin
                            state      <= PREFETCH;
                            ram_addr   <= {rowNext, {COL_BITS{1'b0}}};
                            ram_clk_en <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
